// File: rtl/cryptopen_sha2_pkg.sv
// Shared SHA-2 compression types, rotation amounts and round primitives.
// Primitives take a 64-bit container plus the active word width (32 or 64).
package cryptopen_sha2_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_DONE} sha2_state_e;

  localparam int unsigned ROT_S0_32 [3] = '{2, 13, 22};
  localparam int unsigned ROT_S1_32 [3] = '{6, 11, 25};
  localparam int unsigned ROT_S0_64 [3] = '{28, 34, 39};
  localparam int unsigned ROT_S1_64 [3] = '{14, 18, 41};

  function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n,
                                       input int unsigned w);
    logic [63:0] m;
    m = (w == 64) ? '1 : 64'h0000_0000_ffff_ffff;
    return (((x & m) >> n) | ((x & m) << (w - n))) & m;
  endfunction

  function automatic logic [63:0] ch(input logic [63:0] e, input logic [63:0] f,
                                     input logic [63:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [63:0] maj(input logic [63:0] a, input logic [63:0] b,
                                      input logic [63:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  function automatic logic [63:0] big_sigma0(input logic [63:0] x, input int unsigned w);
    if (w == 64) return rotr(x, ROT_S0_64[0], w) ^ rotr(x, ROT_S0_64[1], w) ^ rotr(x, ROT_S0_64[2], w);
    return rotr(x, ROT_S0_32[0], w) ^ rotr(x, ROT_S0_32[1], w) ^ rotr(x, ROT_S0_32[2], w);
  endfunction

  function automatic logic [63:0] big_sigma1(input logic [63:0] x, input int unsigned w);
    if (w == 64) return rotr(x, ROT_S1_64[0], w) ^ rotr(x, ROT_S1_64[1], w) ^ rotr(x, ROT_S1_64[2], w);
    return rotr(x, ROT_S1_32[0], w) ^ rotr(x, ROT_S1_32[1], w) ^ rotr(x, ROT_S1_32[2], w);
  endfunction

endpackage

// File: rtl/sha2_round_fn.sv
// Combinational single SHA-2 round: working variables a..h plus W_t/K_t -> next a..h.
// Word 7 of the packed state is a, word 0 is h (same order as the chaining value).
module sha2_round_fn
  import cryptopen_sha2_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input  logic [7:0][Width-1:0] cur,
  input  logic [Width-1:0]      w,
  input  logic [Width-1:0]      k,
  output logic [7:0][Width-1:0] nxt
);

  logic [Width-1:0] a, b, c, d, e, f, g, h, t1, t2;

  assign {a, b, c, d, e, f, g, h} = cur;

  assign t1 = h + Width'(big_sigma1(64'(e), Width)) + Width'(ch(64'(e), 64'(f), 64'(g))) + k + w;
  assign t2 = Width'(big_sigma0(64'(a), Width)) + Width'(maj(64'(a), 64'(b), 64'(c)));

  assign nxt = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha2_compress_core.sv
// Iterative SHA-2 compression core (Width 32 = SHA-256, 64 = SHA-512), one round per beat.
// Optional CRYPTOPEN_SHA2_ABORT_EN adds abort_i to drop an in-flight block.
module sha2_compress_core
  import cryptopen_sha2_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
`ifdef CRYPTOPEN_SHA2_ABORT_EN
  input  logic                 abort_i,
`endif
  input  logic                 init_valid_i,
  output logic                 init_ready_o,
  input  logic [8*Width-1:0]   init_state_i,
  input  logic                 wk_valid_i,
  output logic                 wk_ready_o,
  input  logic [Width-1:0]     w_i,
  input  logic [Width-1:0]     k_i,
  output logic                 digest_valid_o,
  input  logic                 digest_ready_i,
  output logic [8*Width-1:0]   digest_o,
  output logic                 busy_o,
  output logic [$clog2(Width == 32 ? 64 : 80)-1:0] round_o
);

  localparam int unsigned NumRounds = (Width == 32) ? 64 : 80;
  localparam int unsigned CntW      = $clog2(NumRounds);

  if (Width != 32 && Width != 64) begin : g_bad_width
    $error("sha2_compress_core: Width must be 32 or 64");
  end

  sha2_state_e             state;
  logic [7:0][Width-1:0]   h_reg, work, nxt, sum, digest;
  logic [CntW-1:0]         cnt;
  logic                    abort;

`ifdef CRYPTOPEN_SHA2_ABORT_EN
  assign abort = abort_i & (state != ST_IDLE);
`else
  assign abort = 1'b0;
`endif

  sha2_round_fn #(.Width(Width)) u_round (
    .cur (work),
    .w   (w_i),
    .k   (k_i),
    .nxt (nxt)
  );

  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < 8; i++) sum[i] = h_reg[i] + nxt[i];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= ST_IDLE;
      h_reg  <= '0;
      work   <= '0;
      digest <= '0;
      cnt    <= '0;
    end else if (abort) begin
      state <= ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: if (init_valid_i) begin
          h_reg <= init_state_i;
          work  <= init_state_i;
          cnt   <= '0;
          state <= ST_ROUND;
        end
        ST_ROUND: if (wk_valid_i) begin
          work <= nxt;
          // The final beat leaves cnt at NumRounds-1; only a new init clears it.
          if (cnt == CntW'(NumRounds - 1)) begin
            digest <= sum;
            state  <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: if (digest_ready_i) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign init_ready_o   = (state == ST_IDLE);
  assign wk_ready_o     = (state == ST_ROUND);
  assign digest_valid_o = (state == ST_DONE);
  assign busy_o         = (state != ST_IDLE);
  assign digest_o       = digest;
  assign round_o        = cnt;

endmodule
